// File: rtl/w5300_reg_bus_arbiter.sv
// w5300_reg_bus_arbiter
// Shares the single W5300 register-access engine between NUM_REQ requesters.
// A requester is picked round-robin, its {dir, addr} word and write data are
// latched onto the engine port, and a one-cycle op_done (with read data) or
// op_timeout pulse is returned to it. A locked requester may chain accesses
// without re-arbitrating; a watchdog abandons an access the engine never ends.

module w5300_reg_bus_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*11-1:0] req_addr,
    input  logic [NUM_REQ*16-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    op_done,
    output logic [NUM_REQ-1:0]    op_timeout,
    output logic [15:0]           rd_data,
    output logic                  bus_start,
    output logic [10:0]           bus_addr,
    output logic [15:0]           bus_wr_data,
    input  logic                  bus_done,
    input  logic [15:0]           bus_rd_data,
    output logic                  busy
);

    localparam int               PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [15:0]      WDOG_LAST = TIMEOUT - 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_last;
    logic [PTR_W-1:0]   w_last_nxt;
    logic [PTR_W-1:0]   r_gidx;
    logic [PTR_W-1:0]   w_gidx_nxt;
    logic [15:0]        r_wdog;
    logic [15:0]        w_wdog_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [NUM_REQ-1:0] r_op_done;
    logic [NUM_REQ-1:0] w_op_done_nxt;
    logic [NUM_REQ-1:0] r_op_timeout;
    logic [NUM_REQ-1:0] w_op_timeout_nxt;
    logic [15:0]        r_rd_data;
    logic [15:0]        w_rd_data_nxt;
    logic               r_bus_start;
    logic               w_bus_start_nxt;
    logic [10:0]        r_bus_addr;
    logic [10:0]        w_bus_addr_nxt;
    logic [15:0]        r_bus_wr_data;
    logic [15:0]        w_bus_wr_data_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    // Per-requester words unpacked from the flat input buses.
    logic [10:0]        w_addr_arr [NUM_REQ];
    logic [15:0]        w_data_arr [NUM_REQ];

    // Round-robin search results.
    logic               w_arb_found;
    logic [PTR_W-1:0]   w_arb_idx;
    logic [NUM_REQ-1:0] w_arb_onehot;
    int                 w_dist;
    int                 w_best;
    logic               w_hit;

    // Signals belonging to the currently granted requester.
    logic               w_req_g;
    logic               w_lock_g;
    logic [10:0]        w_addr_g;
    logic [15:0]        w_data_g;

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi] = req_addr[11*gi +: 11];
        assign w_data_arr[gi] = req_wr_data[16*gi +: 16];
    end

    assign w_req_g  = req[r_gidx];
    assign w_lock_g = req_lock[r_gidx];
    assign w_addr_g = w_addr_arr[r_gidx];
    assign w_data_g = w_data_arr[r_gidx];

    // Winner = requesting index at the smallest cyclic distance after r_last.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = r_last;
        w_best      = NUM_REQ;
        w_dist      = 0;
        w_hit       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Distance 0 means "right after r_last", NUM_REQ-1 means r_last itself.
            w_dist      = (i - int'(r_last) + NUM_REQ - 1) % NUM_REQ;
            w_hit       = req[i] && (w_dist < w_best);
            w_best      = w_hit ? w_dist : w_best;
            w_arb_idx   = w_hit ? PTR_W'(i) : w_arb_idx;
            w_arb_found = w_arb_found | w_hit;
        end
    end

    assign w_arb_onehot = NUM_REQ'(1) << w_arb_idx;

    // Sequencer: next state plus next values of every registered output.
    always_comb begin
        w_state_nxt       = r_state;
        w_last_nxt        = r_last;
        w_gidx_nxt        = r_gidx;
        w_wdog_nxt        = r_wdog;
        w_gnt_nxt         = r_gnt;
        w_op_done_nxt     = '0;
        w_op_timeout_nxt  = '0;
        w_rd_data_nxt     = r_rd_data;
        w_bus_start_nxt   = 1'b0;
        w_bus_addr_nxt    = r_bus_addr;
        w_bus_wr_data_nxt = r_bus_wr_data;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt = ST_ISSUE;
                    w_gidx_nxt  = w_arb_idx;
                    w_gnt_nxt   = w_arb_onehot;
                end else begin
                    w_gnt_nxt   = '0;
                end
            end
            ST_ISSUE: begin
                if (w_req_g) begin
                    // Address/data are sampled here so a locked requester can
                    // advance its sequence during the op_done cycle.
                    w_bus_addr_nxt    = w_addr_g;
                    w_bus_wr_data_nxt = w_data_g;
                    w_bus_start_nxt   = 1'b1;
                    w_wdog_nxt        = 16'd0;
                    w_state_nxt       = ST_WAIT;
                end else begin
                    // Requester withdrew before the strobe: no access, pointer kept.
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus_done) begin
                    // Completion takes priority over a simultaneous watchdog expiry.
                    w_rd_data_nxt = bus_rd_data;
                    w_op_done_nxt = r_gnt;
                    w_state_nxt   = ST_DONE;
                end else if (r_wdog == WDOG_LAST) begin
                    w_op_timeout_nxt = r_gnt;
                    w_gnt_nxt        = '0;
                    w_last_nxt       = r_gidx;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + 16'd1;
                end
            end
            ST_DONE: begin
                if (w_lock_g && w_req_g) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_gidx;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, pointer, grant index and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= LAST_RST;
            r_gidx  <= '0;
            r_wdog  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_gidx  <= w_gidx_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    // Registered outputs toward requesters and the bus engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt         <= '0;
            r_op_done     <= '0;
            r_op_timeout  <= '0;
            r_rd_data     <= 16'd0;
            r_bus_start   <= 1'b0;
            r_bus_addr    <= 11'd0;
            r_bus_wr_data <= 16'd0;
            r_busy        <= 1'b0;
        end else begin
            r_gnt         <= w_gnt_nxt;
            r_op_done     <= w_op_done_nxt;
            r_op_timeout  <= w_op_timeout_nxt;
            r_rd_data     <= w_rd_data_nxt;
            r_bus_start   <= w_bus_start_nxt;
            r_bus_addr    <= w_bus_addr_nxt;
            r_bus_wr_data <= w_bus_wr_data_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign op_done     = r_op_done;
    assign op_timeout  = r_op_timeout;
    assign rd_data     = r_rd_data;
    assign bus_start   = r_bus_start;
    assign bus_addr    = r_bus_addr;
    assign bus_wr_data = r_bus_wr_data;
    assign busy        = r_busy;

endmodule

// File: tb/tb_w5300_reg_bus_arbiter.sv
// tb_w5300_reg_bus_arbiter
// Drives the requesters and a modelled bus engine; expected grants come from a
// modulo-arithmetic round-robin model and expected timing from the documented
// cycle relationships.

module tb_w5300_reg_bus_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_lock;
    logic [N*11-1:0] req_addr;
    logic [N*16-1:0] req_wr_data;
    logic [N-1:0]    gnt;
    logic [N-1:0]    op_done;
    logic [N-1:0]    op_timeout;
    logic [15:0]     rd_data;
    logic            bus_start;
    logic [10:0]     bus_addr;
    logic [15:0]     bus_wr_data;
    logic            bus_done;
    logic [15:0]     bus_rd_data;
    logic            busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int m_last = N - 1;

    // Bus-engine model controls.
    int          resp_lat = 0;   // cycles from bus_start to bus_done, 0 = never
    int          resp_fix = -1;  // fixed read data when >= 0
    int          done_at  = -1;
    logic [15:0] resp_last_rd = 16'd0;

    typedef struct packed { int cyc; logic [N-1:0] g; logic [10:0] a; logic [15:0] d; } start_t;
    typedef struct packed { int cyc; logic [N-1:0] g; logic [15:0] d; } done_t;
    start_t start_q[$];
    done_t  done_q[$];
    done_t  to_q[$];

    w5300_reg_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(16'd8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock),
        .req_addr(req_addr), .req_wr_data(req_wr_data), .gnt(gnt),
        .op_done(op_done), .op_timeout(op_timeout), .rd_data(rd_data),
        .bus_start(bus_start), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_done(bus_done), .bus_rd_data(bus_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus engine: answers each bus_start after resp_lat cycles with read data.
    initial begin
        bus_done    = 1'b0;
        bus_rd_data = 16'd0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_start === 1'b1) done_at = (resp_lat > 0) ? cyc + resp_lat : -1;
            if (cyc == done_at) begin
                bus_done     = 1'b1;
                bus_rd_data  = (resp_fix >= 0) ? 16'(resp_fix) : 16'($urandom);
                resp_last_rd = bus_rd_data;
            end else begin
                bus_done    = 1'b0;
                bus_rd_data = 16'($urandom);
            end
        end
    end

    // Event log sampled on the inactive edge.
    always @(negedge clk) begin
        start_t s;
        done_t  dn;
        if (rst_n === 1'b1) begin
            if (bus_start === 1'b1) begin
                s.cyc = cyc; s.g = gnt; s.a = bus_addr; s.d = bus_wr_data;
                start_q.push_back(s);
            end
            if (|op_done) begin
                dn.cyc = cyc; dn.g = op_done; dn.d = rd_data;
                done_q.push_back(dn);
            end
            if (|op_timeout) begin
                dn.cyc = cyc; dn.g = op_timeout; dn.d = 16'd0;
                to_q.push_back(dn);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 400000");
        $fatal(1);
    end

    // Reference round-robin: first requesting index at last+1, last+2, ... mod N.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int e);
        logic [N-1:0] v;
        v = '0;
        if (e >= 0 && e < N) v[e] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [10:0] a, input logic [15:0] d);
        req_addr[11*i +: 11]    = a;
        req_wr_data[16*i +: 16] = d;
    endtask

    // sel 0: wait for bus_start; sel 1: wait for op_done or op_timeout. n = -1 on expiry.
    task automatic wait_sig(input int sel, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((sel == 0 && bus_start === 1'b1) ||
                (sel == 1 && ((|op_done) || (|op_timeout)))) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        start_q.delete();
        done_q.delete();
        to_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_lock = '0; req_addr = '0; req_wr_data = '0;
        repeat (3) tick();
        n_cmp++;
        if ({gnt, op_done, op_timeout, rd_data, bus_start, bus_addr, bus_wr_data, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {gnt, op_done, op_timeout, rd_data, bus_start, bus_addr, bus_wr_data, busy});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || gnt !== '0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b gnt=%b want 0/0000", busy, gnt);
        end
        m_last = N - 1;
    endtask

    task automatic test_round_robin();
        int exp_g[5];
        int e, n;
        clear_logs();
        for (int i = 0; i < N; i++) set_word(i, 11'($urandom), 16'($urandom));
        resp_lat = 2;
        e = m_last;
        for (int k = 0; k < 5; k++) begin e = rr_pick(4'b1111, e); exp_g[k] = e; end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_sig(1, 40, n);
            if (k == 4) req = '0;
            n_cmp++;
            if (n < 0 || op_done !== onehot(exp_g[k])) begin
                n_fail++; $display("FAIL rr_done[%0d]: got %b (wait %0d) want %b", k, op_done, n, onehot(exp_g[k]));
            end
        end
        repeat (4) tick();
        n_cmp++;
        if (start_q.size() != 5 || done_q.size() != 5) begin
            n_fail++; $display("FAIL rr_counts: starts=%0d dones=%0d want 5/5", start_q.size(), done_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (start_q[k].g !== onehot(exp_g[k]) || start_q[k].a !== req_addr[11*exp_g[k] +: 11]
                    || done_q[k].g !== start_q[k].g) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: gnt=%b addr=%h done=%b want gnt=%b addr=%h", k,
                             start_q[k].g, start_q[k].a, done_q[k].g, onehot(exp_g[k]), req_addr[11*exp_g[k] +: 11]);
                end
            end
        end
        m_last = exp_g[4];
    endtask

    task automatic test_single();
        int n;
        clear_logs();
        set_word(0, 11'h401, 16'h0fa0);
        resp_lat = 5; resp_fix = 16'h1234;
        req = 4'b0001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_gnt: gnt=%b busy=%b want 0001/1", gnt, busy);
        end
        tick();
        n_cmp++;
        if (bus_start !== 1'b1 || bus_addr !== 11'h401 || bus_wr_data !== 16'h0fa0) begin
            n_fail++; $display("FAIL single_start: start=%b addr=%h data=%h want 1/401/0fa0", bus_start, bus_addr, bus_wr_data);
        end
        wait_sig(1, 20, n);
        req = '0;
        n_cmp++;
        if (n != 6 || op_done !== 4'b0001 || rd_data !== 16'h1234) begin
            n_fail++; $display("FAIL single_done: after %0d op_done=%b rd=%h want 6/0001/1234", n, op_done, rd_data);
        end
        tick();
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0 || op_done !== '0) begin
            n_fail++; $display("FAIL single_idle: gnt=%b busy=%b op_done=%b want 0000/0/0000", gnt, busy, op_done);
        end
        resp_fix = -1;
        m_last = 0;
    endtask

    task automatic test_lock();
        logic [10:0] a[3];
        logic [15:0] d[3];
        int k, t, hold_bad, n, e2;
        clear_logs();
        for (int i = 0; i < 3; i++) begin a[i] = 11'($urandom); d[i] = 16'($urandom); end
        set_word(2, 11'($urandom), 16'($urandom));
        set_word(1, a[0], d[0]);
        resp_lat = 3;
        req_lock = 4'b0010;
        req = 4'b0110;
        k = 0; t = 0; hold_bad = 0;
        while (k < 3 && t < 120) begin
            tick(); t++;
            if (gnt !== 4'b0010 && (k > 0 || start_q.size() > 0)) hold_bad++;
            if (|op_done) begin
                k++;
                if (k < 3) set_word(1, a[k], d[k]);
                else begin req_lock = '0; req[1] = 1'b0; end
            end
        end
        n_cmp++;
        if (k != 3 || hold_bad != 0) begin
            n_fail++; $display("FAIL lock_hold: accesses=%0d grant_gaps=%0d want 3/0", k, hold_bad);
        end
        wait_sig(1, 30, n);
        req = '0;
        e2 = rr_pick(4'b0100, 1);
        tick();
        n_cmp++;
        if (start_q.size() != 4) begin
            n_fail++; $display("FAIL lock_count: starts=%0d want 4", start_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (start_q[i].g !== 4'b0010 || start_q[i].a !== a[i] || start_q[i].d !== d[i]) begin
                    n_fail++;
                    $display("FAIL lock_seq[%0d]: gnt=%b addr=%h data=%h want 0010/%h/%h", i,
                             start_q[i].g, start_q[i].a, start_q[i].d, a[i], d[i]);
                end
            end
            n_cmp++;
            if (start_q[1].cyc - start_q[0].cyc != 6 || start_q[2].cyc - start_q[1].cyc != 6) begin
                n_fail++; $display("FAIL lock_spacing: %0d,%0d want 6,6",
                                   start_q[1].cyc - start_q[0].cyc, start_q[2].cyc - start_q[1].cyc);
            end
            n_cmp++;
            if (start_q[3].g !== onehot(e2)) begin
                n_fail++; $display("FAIL lock_next: gnt=%b want %b", start_q[3].g, onehot(e2));
            end
        end
        m_last = e2;
    endtask

    task automatic test_watchdog();
        int n, n2, e;
        clear_logs();
        resp_lat = 0;
        e = rr_pick(4'b1000, m_last);
        req = 4'b1000;
        wait_sig(0, 10, n);
        wait_sig(1, 20, n2);
        req = '0;
        n_cmp++;
        if (n < 0 || n2 != 8 || op_timeout !== onehot(e) || op_done !== '0) begin
            n_fail++; $display("FAIL wd_pulse: after %0d timeout=%b done=%b want 8/%b/0000", n2, op_timeout, op_done, onehot(e));
        end
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wd_release: gnt=%b busy=%b want 0000/0", gnt, busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || op_timeout !== '0) begin
            n_fail++; $display("FAIL wd_idle: busy=%b timeout=%b want 0/0000", busy, op_timeout);
        end
        m_last = e;
        // bus_done on the very cycle the watchdog would expire.
        resp_lat = 7;
        e = rr_pick(4'b0001, m_last);
        req = 4'b0001;
        wait_sig(0, 10, n);
        wait_sig(1, 20, n2);
        req = '0;
        n_cmp++;
        if (n < 0 || n2 != 8 || op_done !== onehot(e) || op_timeout !== '0 || rd_data !== resp_last_rd) begin
            n_fail++; $display("FAIL wd_race: after %0d done=%b timeout=%b rd=%h want 8/%b/0000/%h",
                               n2, op_done, op_timeout, rd_data, onehot(e), resp_last_rd);
        end
        tick();
        n_cmp++;
        if (to_q.size() != 1 || done_q.size() != 1) begin
            n_fail++; $display("FAIL wd_counts: timeouts=%0d dones=%0d want 1/1", to_q.size(), done_q.size());
        end
        m_last = e;
    endtask

    task automatic test_abort_issue();
        int n, e;
        clear_logs();
        req = 4'b1000;
        tick();
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_fail++; $display("FAIL abort_gnt: gnt=%b want 1000", gnt);
        end
        req = '0;
        tick();
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0 || bus_start !== 1'b0) begin
            n_fail++; $display("FAIL abort_clear: gnt=%b busy=%b start=%b want 0000/0/0", gnt, busy, bus_start);
        end
        tick();
        n_cmp++;
        if (start_q.size() != 0) begin
            n_fail++; $display("FAIL abort_nostart: starts=%0d want 0", start_q.size());
        end
        resp_lat = 2;
        e = rr_pick(4'b1001, m_last);
        req = 4'b1001;
        wait_sig(0, 10, n);
        n_cmp++;
        if (n < 0 || gnt !== onehot(e)) begin
            n_fail++; $display("FAIL abort_ptr: gnt=%b want %b", gnt, onehot(e));
        end
        wait_sig(1, 20, n);
        req = '0;
        tick();
        m_last = e;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        int e, n;
        clear_logs();
        for (int i = 0; i < N; i++) set_word(i, 11'($urandom), 16'($urandom));
        r = 4'($urandom_range(1, 15));
        for (int t = 0; t < 24; t++) begin
            resp_lat = $urandom_range(1, 5);
            req = r;
            e = rr_pick(r, m_last);
            wait_sig(1, 40, n);
            n_cmp++;
            if (n < 0 || op_done !== onehot(e) || rd_data !== resp_last_rd) begin
                n_fail++; $display("FAIL rand_done[%0d]: done=%b rd=%h want %b/%h", t, op_done, rd_data, onehot(e), resp_last_rd);
            end
            n_cmp++;
            if (start_q.size() != t + 1) begin
                n_fail++; $display("FAIL rand_count[%0d]: starts=%0d want %0d", t, start_q.size(), t + 1);
            end else if (start_q[t].g !== onehot(e) || start_q[t].a !== req_addr[11*e +: 11]
                         || start_q[t].d !== req_wr_data[16*e +: 16]) begin
                n_fail++; $display("FAIL rand_start[%0d]: gnt=%b addr=%h data=%h want %b/%h/%h", t,
                                   start_q[t].g, start_q[t].a, start_q[t].d, onehot(e),
                                   req_addr[11*e +: 11], req_wr_data[16*e +: 16]);
            end
            m_last = e;
            r = (r & ~onehot(e)) | (4'($urandom) & 4'($urandom));
            if (r == '0) r = onehot($urandom_range(0, N - 1));
            set_word(e, 11'($urandom), 16'($urandom));
            req = r;
            if (n < 0) break;
        end
        req = '0;
        repeat (12) tick();
    endtask

    task automatic test_reset_mid_wait();
        int n, e;
        clear_logs();
        set_word(1, 11'($urandom), 16'($urandom));
        set_word(2, 11'($urandom), 16'($urandom));
        resp_lat = 4;
        req = 4'b0010;
        wait_sig(0, 10, n);
        tick();
        tick();
        rst_n = 1'b0;
        req = '0;
        #1;
        n_cmp++;
        if ({gnt, op_done, op_timeout, rd_data, bus_start, bus_addr, bus_wr_data, busy} !== '0) begin
            n_fail++; $display("FAIL rst_async: got %h want 0",
                               {gnt, op_done, op_timeout, rd_data, bus_start, bus_addr, bus_wr_data, busy});
        end
        tick();
        tick();
        // Release in the cycle where the stale bus_done arrives.
        rst_n = 1'b1;
        resp_lat = 5;
        m_last = N - 1;
        e = rr_pick(4'b0100, m_last);
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== onehot(e) || busy !== 1'b1 || op_done !== '0) begin
            n_fail++; $display("FAIL rst_regrant: gnt=%b busy=%b done=%b want %b/1/0000", gnt, busy, op_done, onehot(e));
        end
        tick();
        n_cmp++;
        if (bus_start !== 1'b1 || bus_addr !== req_addr[11*e +: 11] || done_q.size() != 0) begin
            n_fail++; $display("FAIL rst_restart: start=%b addr=%h dones=%0d want 1/%h/0",
                               bus_start, bus_addr, done_q.size(), req_addr[11*e +: 11]);
        end
        wait_sig(1, 20, n);
        req = '0;
        n_cmp++;
        if (n != 6 || op_done !== onehot(e) || rd_data !== resp_last_rd) begin
            n_fail++; $display("FAIL rst_done: after %0d done=%b rd=%h want 6/%b/%h", n, op_done, rd_data, onehot(e), resp_last_rd);
        end
        tick();
        n_cmp++;
        if (done_q.size() != 1 || to_q.size() != 0) begin
            n_fail++; $display("FAIL rst_counts: dones=%0d timeouts=%0d want 1/0", done_q.size(), to_q.size());
        end
        m_last = e;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_lock();
        test_watchdog();
        test_abort_issue();
        test_random();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
